morph_frame_ctrl: RTL and testbench
===================================

MORPH_FRAME_CTRL -- requirements
Module: morph_frame_ctrl

Interface
REQ-001 Parameter H_SIZE, 10 bits, default 83: expected active pixels per line.
REQ-002 Parameter V_SIZE, 10 bits, default 64: expected active lines per frame.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 ce  in  1  clock enable; when low, every register holds.
REQ-006 cfg_mode  in  3  requested mode: 0 BYPASS, 1 ERODE, 2 DILATE, 3 OPEN, 4 CLOSE; values 5-7 are treated as BYPASS.
REQ-007 cfg_valid  in  1  cfg_mode offered.
REQ-008 cfg_ready  out  1  controller can accept a config.
REQ-009 in_de, in_hsync, in_vsync  in  1 each  incoming video timing.
REQ-010 st1_op, st2_op  out  1 each  stage operation: 0 erode, 1 dilate.
REQ-011 st1_byp, st2_byp  out  1 each  stage bypass.
REQ-012 mode_act  out  3  mode currently applied.
REQ-013 cfg_ack  out  1  one-cycle pulse when a pending mode is applied.
REQ-014 busy  out  1  high while a frame is active.
REQ-015 frame_cnt  out  16  frames started since reset.
REQ-016 hlen_err, vlen_err  out  1 each  sticky geometry errors.

Function
REQ-017 Handshake: a config is accepted in a cycle when cfg_valid=1, cfg_ready=1 and ce=1; the mode is stored in a pending register and pend_flag is set.
REQ-018 cfg_ready shall equal NOT pend_flag.
REQ-019 Frame start is the cycle where in_vsync=1 and its registered value is 0 (rising edge).
REQ-020 At frame start with pend_flag=1: mode_act <= pending mode, stage outputs update, cfg_ack=1 for that cycle, and pend_flag is cleared.
REQ-021 Config acceptance in the same cycle as frame start goes to pending and is applied only at the next frame start.
REQ-022 Stage map per mode as (st1_op, st1_byp, st2_op, st2_byp):
  - BYPASS = (0,1,1,1)
  - ERODE = (0,0,1,1)
  - DILATE = (0,1,1,0)
  - OPEN = (0,0,1,0)
  - CLOSE = (1,0,0,0)
REQ-023 Stage outputs change only at frame start, never mid-frame.
REQ-024 States:
  - IDLE: after reset; goes to VSYNC on frame start.
  - VSYNC: goes to ACTIVE on the first in_de=1.
  - ACTIVE: goes to VSYNC on the next frame start.
REQ-025 busy shall be 1 in ACTIVE and 0 otherwise.
REQ-026 frame_cnt increments by 1 at every frame start and wraps from 65535 to 0.
REQ-027 Pixel counter (10 bits): counts in_de=1 cycles; resets on the falling edge of in_de; saturates at 1023.
REQ-028 Line counter (10 bits): increments on each falling edge of in_de and saturates at 1023.
REQ-029 On each in_de falling edge, a pixel count including the final pixel that is not equal to H_SIZE sets hlen_err.
REQ-030 At frame start in state ACTIVE, a line count not equal to V_SIZE sets vlen_err; the line counter then clears. A frame start from IDLE does not check the line count.
REQ-031 hlen_err and vlen_err clear only on reset or on cfg_ack.
REQ-032 If an error-set condition and cfg_ack occur in the same cycle, the set wins.
REQ-033 in_hsync has no effect on state and exists only for pipeline alignment.

Reset
REQ-034 rst_n=0 forces the following immediately, regardless of ce:
  - state IDLE, mode_act 0, pend_flag 0
  - st1_op 0, st1_byp 1, st2_op 1, st2_byp 1
  - cfg_ack 0, busy 0, frame_cnt 0
  - counters 0, hlen_err 0, vlen_err 0
  - registered in_vsync and in_de 0
REQ-035 Reset asserted mid-frame discards the pending config and the partial counts; after release, the block waits in IDLE for the next frame start.

Structure
REQ-036 Mode codes, the stage-map table and state encodings shall reside in a shared package, morph_pkg.
REQ-037 Geometry checking shall be one sub-module, morph_geom_chk, holding the pixel and line counters and the error flags.

Verification
REQ-038 Reset, then 3 frames of 64 lines x 83 pixels with no config -> mode_act=0, all bypass bits 1, frame_cnt=3, no errors.
REQ-039 cfg_mode=3 accepted mid-frame 1 -> cfg_ready=0 until frame 2 start; at frame 2 start cfg_ack pulses once; stage outputs become (0,0,1,0); outputs stay unchanged during frame 1.
REQ-040 cfg_valid coincident with frame start (mode=4) -> applied at the following frame start, not the current one.
REQ-041 One line of 82 pixels -> hlen_err=1 after that line; a frame of 63 lines -> vlen_err=1 at the next start; both clear on the next cfg_ack.
REQ-042 rst_n pulsed low mid-frame with a pending config -> all outputs return to reset values asynchronously; no cfg_ack at the next frame start.
REQ-043 ce=0 for 10 cycles during a line -> counters and state freeze; the line count still matches, with no false hlen_err.

Source files
------------

// File: rtl/morph_pkg.sv
// Shared definitions for the morphology frame controller.
//   mode_e      : filter mode codes as presented on cfg_mode
//   state_e     : frame-tracking states of the controller
//   stage_cfg_t : per-stage operation/bypass bits driven to the filter pipe
//   stage_map   : mode -> stage configuration table
//   mode_decode : folds the unused mode codes onto BYPASS
package morph_pkg;

  typedef enum logic [2:0] {
    MODE_BYPASS = 3'd0,
    MODE_ERODE  = 3'd1,
    MODE_DILATE = 3'd2,
    MODE_OPEN   = 3'd3,
    MODE_CLOSE  = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VSYNC  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  // op: 0 erode, 1 dilate; byp: 1 passes the stage through untouched
  typedef struct packed {
    logic st1_op;
    logic st1_byp;
    logic st2_op;
    logic st2_byp;
  } stage_cfg_t;

  localparam stage_cfg_t STAGE_BYPASS = '{1'b0, 1'b1, 1'b1, 1'b1};

  function automatic stage_cfg_t stage_map(mode_e m);
    case (m)
      MODE_ERODE:  return '{1'b0, 1'b0, 1'b1, 1'b1};
      MODE_DILATE: return '{1'b0, 1'b1, 1'b1, 1'b0};
      MODE_OPEN:   return '{1'b0, 1'b0, 1'b1, 1'b0};
      MODE_CLOSE:  return '{1'b1, 1'b0, 1'b0, 1'b0};
      default:     return STAGE_BYPASS;
    endcase
  endfunction

  function automatic mode_e mode_decode(logic [2:0] raw);
    if (raw > 3'd4) return MODE_BYPASS;
    return mode_e'(raw);
  endfunction

endpackage

// File: rtl/morph_frame_ctrl_if.sv
// Configuration handshake and incoming video timing of the morphology
// frame controller.
//   cfg_mode/cfg_valid/cfg_ready : mode request handshake
//   in_de/in_hsync/in_vsync      : video timing from the pixel source
// master: the side driving config and timing; slave: the controller.
interface morph_frame_ctrl_if;
  logic [2:0] cfg_mode;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       in_de;
  logic       in_hsync;
  logic       in_vsync;

  modport master (
    output cfg_mode, cfg_valid, in_de, in_hsync, in_vsync,
    input  cfg_ready
  );

  modport slave (
    input  cfg_mode, cfg_valid, in_de, in_hsync, in_vsync,
    output cfg_ready
  );
endinterface

// File: rtl/morph_geom_chk.sv
// Frame geometry checker: counts pixels per line and lines per frame and
// raises sticky length errors.
//   clk, rst_n  : clock, asynchronous active-low reset
//   pix_en      : an active pixel this cycle (already qualified by ce)
//   line_end    : falling edge of data enable (already qualified by ce)
//   frame_start : rising edge of vsync (already qualified by ce)
//   chk_lines   : frame start ends a frame that carried active video
//   err_clr     : clears both sticky errors (a pending mode was applied)
//   hlen_err    : a line ended with a pixel count other than H_SIZE
//   vlen_err    : a frame ended with a line count other than V_SIZE
module morph_geom_chk #(
  parameter logic [9:0] H_SIZE = 10'd83,
  parameter logic [9:0] V_SIZE = 10'd64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pix_en,
  input  logic line_end,
  input  logic frame_start,
  input  logic chk_lines,
  input  logic err_clr,
  output logic hlen_err,
  output logic vlen_err
);

  localparam logic [9:0] CNT_MAX = 10'h3FF;

  logic [9:0] pix_cnt;
  logic [9:0] line_cnt;
  logic [9:0] line_nxt;
  logic       hlen_set;
  logic       vlen_set;

  // line count including a line that happens to end in this very cycle
  always_comb begin
    line_nxt = line_cnt;
    if (line_end && (line_cnt != CNT_MAX)) line_nxt = line_cnt + 10'd1;
  end

  // the final pixel of a line was counted in the cycle before de fell
  assign hlen_set = line_end && (pix_cnt != H_SIZE);
  assign vlen_set = frame_start && chk_lines && (line_nxt != V_SIZE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
      hlen_err <= 1'b0;
      vlen_err <= 1'b0;
    end else begin
      if (line_end)
        pix_cnt <= '0;
      else if (pix_en && (pix_cnt != CNT_MAX))
        pix_cnt <= pix_cnt + 10'd1;

      line_cnt <= frame_start ? 10'd0 : line_nxt;

      // a new error in the clearing cycle must not be lost
      if (hlen_set)     hlen_err <= 1'b1;
      else if (err_clr) hlen_err <= 1'b0;
      if (vlen_set)     vlen_err <= 1'b1;
      else if (err_clr) vlen_err <= 1'b0;
    end
  end

endmodule

// File: rtl/morph_frame_ctrl.sv
// Morphology frame controller: accepts a filter mode through a ready/valid
// handshake and applies it to the two filter stages only at a frame start,
// tracks frame state and counts frames, and checks frame geometry.
//   clk, rst_n   : clock, asynchronous active-low reset
//   ce           : clock enable, all registers hold while low
//   bus (slave)  : cfg_mode/cfg_valid/cfg_ready, in_de/in_hsync/in_vsync
//   st1_op/st1_byp, st2_op/st2_byp : stage operation and bypass
//   mode_act     : mode currently applied
//   cfg_ack      : one-cycle pulse when a pending mode takes effect
//   busy         : a frame with active video is in progress
//   frame_cnt    : frame starts since reset (wrapping)
//   hlen_err/vlen_err : sticky geometry errors
module morph_frame_ctrl
  import morph_pkg::*;
#(
  parameter logic [9:0] H_SIZE = 10'd83,
  parameter logic [9:0] V_SIZE = 10'd64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  morph_frame_ctrl_if.slave   bus,
  output logic                st1_op,
  output logic                st1_byp,
  output logic                st2_op,
  output logic                st2_byp,
  output logic [2:0]          mode_act,
  output logic                cfg_ack,
  output logic                busy,
  output logic [15:0]         frame_cnt,
  output logic                hlen_err,
  output logic                vlen_err
);

  state_e     state;
  state_e     state_nxt;
  logic       vsync_p1;
  logic       de_p1;
  logic       pend_flag;
  mode_e      pend_mode;
  mode_e      mode_q;
  stage_cfg_t stage_cfg;

  logic frame_start;
  logic line_end;
  logic accept;
  logic apply;

  assign frame_start = ce && bus.in_vsync && !vsync_p1;
  assign line_end    = ce && !bus.in_de && de_p1;
  assign accept      = ce && bus.cfg_valid && !pend_flag;
  // a mode accepted in the frame-start cycle itself waits for the next start
  assign apply       = frame_start && pend_flag;

  assign bus.cfg_ready = !pend_flag;

  // stage bits follow mode_act, which only moves at a frame start
  assign stage_cfg = stage_map(mode_q);
  assign st1_op    = stage_cfg.st1_op;
  assign st1_byp   = stage_cfg.st1_byp;
  assign st2_op    = stage_cfg.st2_op;
  assign st2_byp   = stage_cfg.st2_byp;
  assign mode_act  = mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else if (ce) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_start) state_nxt = ST_VSYNC;
      end
      ST_VSYNC: begin
        if (!frame_start && bus.in_de) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        busy = 1'b1;
        if (frame_start) state_nxt = ST_VSYNC;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_p1  <= 1'b0;
      de_p1     <= 1'b0;
      pend_flag <= 1'b0;
      pend_mode <= MODE_BYPASS;
      mode_q    <= MODE_BYPASS;
      cfg_ack   <= 1'b0;
      frame_cnt <= '0;
    end else if (ce) begin
      vsync_p1 <= bus.in_vsync;
      de_p1    <= bus.in_de;
      cfg_ack  <= apply;
      if (frame_start) frame_cnt <= frame_cnt + 16'd1;
      if (apply) begin
        mode_q    <= pend_mode;
        pend_flag <= 1'b0;
      end else if (accept) begin
        pend_mode <= mode_decode(bus.cfg_mode);
        pend_flag <= 1'b1;
      end
    end
  end

  morph_geom_chk #(
    .H_SIZE (H_SIZE),
    .V_SIZE (V_SIZE)
  ) u_geom (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (ce && bus.in_de),
    .line_end    (line_end),
    .frame_start (frame_start),
    .chk_lines   (state == ST_ACTIVE),
    .err_clr     (apply),
    .hlen_err    (hlen_err),
    .vlen_err    (vlen_err)
  );

endmodule

// File: tb/tb_morph_frame_ctrl.sv
// Bench for morph_frame_ctrl: directed frames with a reference model that
// tracks the expected outputs from frame/line events, checked every cycle,
// plus literal expectations at key points of the scenario.
module tb_morph_frame_ctrl;

  localparam int H = 83;
  localparam int V = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b1;
  logic        st1_op, st1_byp, st2_op, st2_byp;
  logic [2:0]  mode_act;
  logic        cfg_ack;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        hlen_err, vlen_err;

  morph_frame_ctrl_if bus ();

  morph_frame_ctrl #(.H_SIZE(10'd83), .V_SIZE(10'd64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .bus       (bus),
    .st1_op    (st1_op),
    .st1_byp   (st1_byp),
    .st2_op    (st2_op),
    .st2_byp   (st2_byp),
    .mode_act  (mode_act),
    .cfg_ack   (cfg_ack),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .hlen_err  (hlen_err),
    .vlen_err  (vlen_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_ack = 0;

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // stage bits (st1_op, st1_byp, st2_op, st2_byp) per mode code
  logic [3:0] stage_tbl [5] = '{4'b0111, 4'b0011, 4'b0110, 4'b0010, 4'b1000};

  function automatic int stage_bits();
    return int'({st1_op, st1_byp, st2_op, st2_byp});
  endfunction

  // ---------------- reference model ----------------
  bit        m_vs, m_de, m_pend, m_ack, m_started, m_busy, m_herr, m_verr;
  int        m_pmode, m_mode, m_pix, m_lines;
  bit [15:0] m_fcnt;

  initial begin
    bit fs, fall, apply, hset, vset;
    int lines_now;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_vs = 0; m_de = 0; m_pend = 0; m_ack = 0; m_started = 0;
        m_busy = 0; m_herr = 0; m_verr = 0; m_pmode = 0; m_mode = 0;
        m_pix = 0; m_lines = 0; m_fcnt = '0;
      end else if (ce) begin
        fs        = bus.in_vsync && !m_vs;
        fall      = !bus.in_de && m_de;
        apply     = fs && m_pend;
        hset      = fall && (m_pix != H);
        lines_now = fall ? ((m_lines < 1023) ? m_lines + 1 : 1023) : m_lines;
        vset      = fs && m_busy && (lines_now != V);

        m_ack = apply;
        if (fs) m_fcnt = m_fcnt + 16'd1;
        if (apply) begin
          m_mode = m_pmode;
          m_pend = 0;
        end else if (bus.cfg_valid && !m_pend) begin
          m_pmode = (int'(bus.cfg_mode) > 4) ? 0 : int'(bus.cfg_mode);
          m_pend  = 1;
        end
        if (apply) begin m_herr = 0; m_verr = 0; end
        if (hset) m_herr = 1;
        if (vset) m_verr = 1;
        m_lines = fs ? 0 : lines_now;
        if (fall) m_pix = 0;
        else if (bus.in_de && m_pix < 1023) m_pix++;
        if (fs) begin
          m_busy = 0;
          m_started = 1;
        end else if (m_started && bus.in_de) begin
          m_busy = 1;
        end
        m_vs = bus.in_vsync;
        m_de = bus.in_de;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (cfg_ack) n_ack++;
      check("cfg_ready", int'(bus.cfg_ready), int'(!m_pend));
      check("mode_act", int'(mode_act), m_mode);
      check("stage", stage_bits(), int'(stage_tbl[m_mode]));
      check("cfg_ack", int'(cfg_ack), int'(m_ack));
      check("busy", int'(busy), int'(m_busy));
      check("frame_cnt", int'(frame_cnt), int'(m_fcnt));
      check("hlen_err", int'(hlen_err), int'(m_herr));
      check("vlen_err", int'(vlen_err), int'(m_verr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse(bit with_cfg, logic [2:0] m);
    bus.in_vsync = 1'b1;
    if (with_cfg) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_mode  = m;
    end
    tick();
    bus.cfg_valid = 1'b0;
    tick();
    bus.in_vsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic lines(int n, int short_idx, int cfg_line, logic [2:0] m, int pause_line);
    for (int l = 0; l < n; l++) begin
      if (l == cfg_line) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_mode  = m;
      end
      for (int p = 0; p < ((l == short_idx) ? H - 1 : H); p++) begin
        if (l == pause_line && p == 40) begin
          ce = 1'b0;
          repeat (10) tick();
          ce = 1'b1;
        end
        bus.in_de = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
      end
      bus.in_de    = 1'b0;
      bus.in_hsync = 1'b1;
      tick();
      bus.in_hsync = 1'b0;
      tick();
      tick();
    end
  endtask

  initial begin
    int a0;
    bus.cfg_mode  = 3'd0;
    bus.cfg_valid = 1'b0;
    bus.in_de     = 1'b0;
    bus.in_hsync  = 1'b0;
    bus.in_vsync  = 1'b0;
    repeat (3) tick();
    check("rst_ready", int'(bus.cfg_ready), 1);
    check("rst_mode", int'(mode_act), 0);
    check("rst_stage", stage_bits(), 'b0111);
    check("rst_fcnt", int'(frame_cnt), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // three plain frames
    for (int f = 0; f < 3; f++) begin
      vs_pulse(1'b0, 3'd0);
      lines(V, -1, -1, 3'd0, -1);
    end
    check("f3_fcnt", int'(frame_cnt), 3);
    check("f3_mode", int'(mode_act), 0);
    check("f3_stage", stage_bits(), 'b0111);
    check("f3_errs", int'({hlen_err, vlen_err}), 0);
    check("f3_busy", int'(busy), 1);

    // OPEN requested mid-frame, applied at the next start
    vs_pulse(1'b0, 3'd0);
    lines(20, -1, 10, 3'd3, -1);
    check("mid_ready", int'(bus.cfg_ready), 0);
    check("mid_stage", stage_bits(), 'b0111);
    lines(V - 20, -1, -1, 3'd0, -1);
    check("end_mode", int'(mode_act), 0);
    a0 = n_ack;
    vs_pulse(1'b0, 3'd0);
    check("open_ack_once", n_ack - a0, 1);
    check("open_mode", int'(mode_act), 3);
    check("open_stage", stage_bits(), 'b0010);
    check("open_ready", int'(bus.cfg_ready), 1);
    lines(V, -1, -1, 3'd0, -1);

    // CLOSE offered in the frame-start cycle itself
    vs_pulse(1'b1, 3'd4);
    check("coinc_mode", int'(mode_act), 3);
    check("coinc_ready", int'(bus.cfg_ready), 0);
    lines(V, -1, -1, 3'd0, -1);
    check("coinc_hold", stage_bits(), 'b0010);
    vs_pulse(1'b0, 3'd0);
    check("close_mode", int'(mode_act), 4);
    check("close_stage", stage_bits(), 'b1000);
    lines(V, -1, -1, 3'd0, -1);

    // short line, then a short frame
    vs_pulse(1'b0, 3'd0);
    lines(6, 5, -1, 3'd0, -1);
    check("short_hlen", int'(hlen_err), 1);
    check("short_vlen0", int'(vlen_err), 0);
    lines(V - 7, -1, -1, 3'd0, -1);
    vs_pulse(1'b0, 3'd0);
    check("short_vlen", int'(vlen_err), 1);
    check("short_hlen_sticky", int'(hlen_err), 1);
    lines(V, -1, 10, 3'd1, -1);
    vs_pulse(1'b0, 3'd0);
    check("ack_clr_errs", int'({hlen_err, vlen_err}), 0);
    check("erode_stage", stage_bits(), 'b0011);

    // clock-enable pause in the middle of a line
    lines(V, -1, -1, 3'd0, 20);
    vs_pulse(1'b0, 3'd0);
    check("ce_errs", int'({hlen_err, vlen_err}), 0);
    check("ce_fcnt", int'(frame_cnt), 11);

    // asynchronous reset mid-frame with a pending DILATE
    lines(15, -1, 10, 3'd2, -1);
    check("pend_ready", int'(bus.cfg_ready), 0);
    bus.in_de = 1'b1;
    repeat (30) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_mode", int'(mode_act), 0);
    check("arst_ready", int'(bus.cfg_ready), 1);
    check("arst_fcnt", int'(frame_cnt), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_stage", stage_bits(), 'b0111);
    bus.in_de = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    a0 = n_ack;
    vs_pulse(1'b0, 3'd0);
    check("post_rst_noack", n_ack - a0, 0);
    check("post_rst_fcnt", int'(frame_cnt), 1);
    check("post_rst_mode", int'(mode_act), 0);
    lines(V, -1, -1, 3'd0, -1);
    vs_pulse(1'b0, 3'd0);
    check("post_rst_f2", int'(frame_cnt), 2);
    check("post_rst_errs", int'({hlen_err, vlen_err}), 0);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
